// File: rtl/st_channel_prefix_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : st_channel_prefix_pipe_if
// Purpose  : Prefix stream, Avalon-ST sink and Avalon-ST source bundle for
//            st_channel_prefix_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface st_channel_prefix_pipe_if #(
    parameter int DATA_W   = 12,
    parameter int CHAN_W   = 5,
    parameter int PREFIX_W = 2
);
    // Prefix stream
    logic                         prefix_valid;
    logic                         prefix_ready;
    logic [PREFIX_W-1:0]          prefix_data;

    // Avalon-ST sink
    logic                         STin_valid;
    logic                         STin_ready;
    logic [DATA_W-1:0]            STin_data;
    logic [CHAN_W-1:0]            STin_channel;
    logic                         STin_startofpacket;
    logic                         STin_endofpacket;

    // Avalon-ST source
    logic                         STout_ready;
    logic                         STout_valid;
    logic [DATA_W-1:0]            STout_data;
    logic [PREFIX_W+CHAN_W-1:0]   STout_channel;
    logic                         STout_startofpacket;
    logic                         STout_endofpacket;

    // Block-side view
    modport slave (
        input  prefix_valid, prefix_data,
        output prefix_ready,
        input  STin_valid, STin_data, STin_channel,
        input  STin_startofpacket, STin_endofpacket,
        output STin_ready,
        input  STout_ready,
        output STout_valid, STout_data, STout_channel,
        output STout_startofpacket, STout_endofpacket
    );

    // Environment-side view
    modport master (
        output prefix_valid, prefix_data,
        input  prefix_ready,
        output STin_valid, STin_data, STin_channel,
        output STin_startofpacket, STin_endofpacket,
        input  STin_ready,
        output STout_ready,
        input  STout_valid, STout_data, STout_channel,
        input  STout_startofpacket, STout_endofpacket
    );
endinterface
`default_nettype wire

// File: rtl/st_channel_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module   : st_channel_prefix_pipe
// Purpose  : Prepends a prefix (per packet or per beat) to the Avalon-ST
//            channel through a 2-entry registered skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module st_channel_prefix_pipe #(
    parameter int DATA_W      = 12,
    parameter int CHAN_W      = 5,
    parameter int PREFIX_W    = 2,
    parameter int PACKET_LOCK = 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    st_channel_prefix_pipe_if.slave   st,
    output logic                      in_packet
);

    localparam int OCH_W = PREFIX_W + CHAN_W;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_IN_PKT = 1'b1;

    logic [0:0]          r_state;
    logic [PREFIX_W-1:0] r_prefix;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [OCH_W-1:0]    r_out_chan;
    logic                r_out_sop;
    logic                r_out_eop;

    logic                r_skid_valid;
    logic [DATA_W-1:0]   r_skid_data;
    logic [OCH_W-1:0]    r_skid_chan;
    logic                r_skid_sop;
    logic                r_skid_eop;

    logic                w_need_prefix;
    logic                w_space;
    logic                w_in_ready;
    logic                w_pfx_ready;
    logic                w_accept;
    logic                w_main_open;
    logic [PREFIX_W-1:0] w_prefix;
    logic [OCH_W-1:0]    w_chan;

    assign w_need_prefix = (PACKET_LOCK == 0) || (r_state == S_IDLE);
    assign w_space       = !r_skid_valid;

    // Readies are held low during reset even though the flops already read empty.
    assign w_in_ready  = !reset && w_space && (!w_need_prefix || st.prefix_valid);
    assign w_pfx_ready = !reset && w_space && w_need_prefix && st.STin_valid;
    assign w_accept    = st.STin_valid && w_in_ready;
    assign w_main_open = !r_out_valid || st.STout_ready;

    assign w_prefix = w_need_prefix ? st.prefix_data : r_prefix;
    assign w_chan   = {w_prefix, st.STin_channel};

    assign st.STin_ready   = w_in_ready;
    assign st.prefix_ready = w_pfx_ready;

    assign st.STout_valid         = r_out_valid;
    assign st.STout_data          = r_out_data;
    assign st.STout_channel       = r_out_chan;
    assign st.STout_startofpacket = r_out_sop;
    assign st.STout_endofpacket   = r_out_eop;

    assign in_packet = (r_state == S_IN_PKT);

    // Packet tracking: a prefix is consumed only when a beat arrives in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_prefix <= '0;
        end else if (w_accept) begin
            if (w_need_prefix) begin
                r_prefix <= st.prefix_data;
            end
            case (r_state)
                S_IDLE: begin
                    if ((PACKET_LOCK != 0) && !st.STin_endofpacket) begin
                        r_state <= S_IN_PKT;
                    end
                end
                S_IN_PKT: begin
                    if (st.STin_endofpacket) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Main register refills from skid first so beat order is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_chan  <= '0;
            r_skid_sop   <= 1'b0;
            r_skid_eop   <= 1'b0;
        end else begin
            if (w_main_open) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_chan   <= r_skid_chan;
                    r_out_sop    <= r_skid_sop;
                    r_out_eop    <= r_skid_eop;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= st.STin_data;
                    r_out_chan  <= w_chan;
                    r_out_sop   <= st.STin_startofpacket;
                    r_out_eop   <= st.STin_endofpacket;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= st.STin_data;
                r_skid_chan  <= w_chan;
                r_skid_sop   <= st.STin_startofpacket;
                r_skid_eop   <= st.STin_endofpacket;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_st_channel_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_channel_prefix_pipe
// Purpose  : Directed self-checking bench for st_channel_prefix_pipe
//            (packet-locked and per-beat prefix instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_st_channel_prefix_pipe;

    logic clk;
    logic reset;
    logic in_packet;
    logic in_packet_nl;
    int   n_checks;
    int   n_fail;

    st_channel_prefix_pipe_if #(.DATA_W(12), .CHAN_W(5), .PREFIX_W(2)) bus ();
    st_channel_prefix_pipe_if #(.DATA_W(12), .CHAN_W(5), .PREFIX_W(2)) bus_nl ();

    st_channel_prefix_pipe #(.DATA_W(12), .CHAN_W(5), .PREFIX_W(2), .PACKET_LOCK(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .st        (bus),
        .in_packet (in_packet)
    );

    st_channel_prefix_pipe #(.DATA_W(12), .CHAN_W(5), .PREFIX_W(2), .PACKET_LOCK(0)) dut_nl (
        .clk       (clk),
        .reset     (reset),
        .st        (bus_nl),
        .in_packet (in_packet_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] d, input logic [4:0] ch,
                         input logic sop, input logic eop, input logic pv, input logic [1:0] pd);
        bus.STin_valid         = v;
        bus.STin_data          = d;
        bus.STin_channel       = ch;
        bus.STin_startofpacket = sop;
        bus.STin_endofpacket   = eop;
        bus.prefix_valid       = pv;
        bus.prefix_data        = pd;
    endtask

    task automatic test_reset();
        drive(1'b1, 12'hFFF, 5'h1F, 1'b1, 1'b1, 1'b1, 2'b11);
        bus.STout_ready = 1'b1;
        #1;
        n_checks++; if (bus.STin_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stin_ready: got %b want 0", bus.STin_ready); end
        n_checks++; if (bus.prefix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_prefix_ready: got %b want 0", bus.prefix_ready); end
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.STout_valid); end
        n_checks++; if ({bus.STout_data, bus.STout_channel, bus.STout_startofpacket, bus.STout_endofpacket} !== 21'h0) begin
            n_fail++; $display("FAIL rst_payload: got %h/%h/%b/%b want 0", bus.STout_data, bus.STout_channel, bus.STout_startofpacket, bus.STout_endofpacket); end
        n_checks++; if (in_packet !== 1'b0) begin n_fail++; $display("FAIL rst_in_packet: got %b want 0", in_packet); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_packet_lock();
        bus.STout_ready = 1'b1;
        drive(1'b1, 12'h0A1, 5'h03, 1'b1, 1'b0, 1'b1, 2'b10);
        #1;
        n_checks++; if (bus.prefix_ready !== 1'b1) begin n_fail++; $display("FAIL pl_b0_pready: got %b want 1", bus.prefix_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_data !== 12'h0A1 || bus.STout_channel !== 7'h43) begin
            n_fail++; $display("FAIL pl_b0_out: got v%b d%h c%h want v1 d0a1 c43", bus.STout_valid, bus.STout_data, bus.STout_channel); end
        n_checks++; if (in_packet !== 1'b1) begin n_fail++; $display("FAIL pl_in_packet_b0: got %b want 1", in_packet); end
        drive(1'b1, 12'h0A2, 5'h03, 1'b0, 1'b0, 1'b1, 2'b01);
        #1;
        n_checks++; if (bus.prefix_ready !== 1'b0 || bus.STin_ready !== 1'b1) begin
            n_fail++; $display("FAIL pl_b1_ready: got pready %b inready %b want 0 1", bus.prefix_ready, bus.STin_ready); end
        step();
        n_checks++; if (bus.STout_data !== 12'h0A2 || bus.STout_channel !== 7'h43) begin
            n_fail++; $display("FAIL pl_b1_out: got d%h c%h want d0a2 c43", bus.STout_data, bus.STout_channel); end
        drive(1'b1, 12'h0A3, 5'h03, 1'b0, 1'b1, 1'b1, 2'b01);
        step();
        n_checks++; if (bus.STout_data !== 12'h0A3 || bus.STout_channel !== 7'h43 || bus.STout_endofpacket !== 1'b1) begin
            n_fail++; $display("FAIL pl_b2_out: got d%h c%h e%b want d0a3 c43 e1", bus.STout_data, bus.STout_channel, bus.STout_endofpacket); end
        n_checks++; if (in_packet !== 1'b0) begin n_fail++; $display("FAIL pl_in_packet_end: got %b want 0", in_packet); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL pl_drain: got %b want 0", bus.STout_valid); end
    endtask

    task automatic test_prefix_wait();
        drive(1'b1, 12'h055, 5'h1A, 1'b1, 1'b1, 1'b0, 2'b01);
        #1;
        n_checks++; if (bus.STin_ready !== 1'b0) begin n_fail++; $display("FAIL pw_ready_noprefix: got %b want 0", bus.STin_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL pw_no_output: got %b want 0", bus.STout_valid); end
        bus.prefix_valid = 1'b1;
        #1;
        n_checks++; if (bus.STin_ready !== 1'b1 || bus.prefix_ready !== 1'b1) begin
            n_fail++; $display("FAIL pw_ready_prefix: got in %b pfx %b want 1 1", bus.STin_ready, bus.prefix_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_channel !== 7'h3A || bus.STout_data !== 12'h055) begin
            n_fail++; $display("FAIL pw_out: got v%b d%h c%h want v1 d055 c3a", bus.STout_valid, bus.STout_data, bus.STout_channel); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
    endtask

    task automatic test_stall();
        bus.STout_ready = 1'b0;
        drive(1'b1, 12'h001, 5'h04, 1'b1, 1'b0, 1'b1, 2'b11);
        step();
        drive(1'b1, 12'h002, 5'h04, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        n_checks++; if (bus.STin_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready_b1: got %b want 1", bus.STin_ready); end
        step();
        drive(1'b1, 12'h003, 5'h04, 1'b0, 1'b1, 1'b0, 2'b00);
        #1;
        n_checks++; if (bus.STin_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready_full: got %b want 0", bus.STin_ready); end
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_data !== 12'h001) begin
            n_fail++; $display("FAIL st_hold1: got v%b d%h want v1 d001", bus.STout_valid, bus.STout_data); end
        step();
        n_checks++; if (bus.STout_data !== 12'h001 || bus.STout_channel !== 7'h64 || bus.STout_startofpacket !== 1'b1) begin
            n_fail++; $display("FAIL st_hold2: got d%h c%h s%b want d001 c64 s1", bus.STout_data, bus.STout_channel, bus.STout_startofpacket); end
        bus.STout_ready = 1'b1;
        #1;
        n_checks++; if (bus.STin_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready_release: got %b want 0", bus.STin_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_data !== 12'h002 || bus.STout_channel !== 7'h64) begin
            n_fail++; $display("FAIL st_out2: got v%b d%h c%h want v1 d002 c64", bus.STout_valid, bus.STout_data, bus.STout_channel); end
        n_checks++; if (bus.STin_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready_reopen: got %b want 1", bus.STin_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_data !== 12'h003 || bus.STout_endofpacket !== 1'b1) begin
            n_fail++; $display("FAIL st_out3: got v%b d%h e%b want v1 d003 e1", bus.STout_valid, bus.STout_data, bus.STout_endofpacket); end
        n_checks++; if (in_packet !== 1'b0) begin n_fail++; $display("FAIL st_in_packet: got %b want 0", in_packet); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL st_no_dup: got %b want 0", bus.STout_valid); end
    endtask

    task automatic test_no_lock();
        logic [6:0] exp_ch;
        bus_nl.STout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_nl.STin_valid         = 1'b1;
            bus_nl.STin_data          = 12'h100 + 12'(i);
            bus_nl.STin_channel       = 5'h07;
            bus_nl.STin_startofpacket = (i == 0);
            bus_nl.STin_endofpacket   = (i == 3);
            bus_nl.prefix_valid       = 1'b1;
            bus_nl.prefix_data        = 2'(i);
            #1;
            n_checks++; if (bus_nl.prefix_ready !== 1'b1) begin n_fail++; $display("FAIL nl_pready_%0d: got %b want 1", i, bus_nl.prefix_ready); end
            step();
            exp_ch = {2'(i), 5'h07};
            n_checks++; if (bus_nl.STout_valid !== 1'b1 || bus_nl.STout_channel !== exp_ch || bus_nl.STout_data !== 12'h100 + 12'(i)) begin
                n_fail++; $display("FAIL nl_out_%0d: got v%b d%h c%h want v1 d%h c%h", i, bus_nl.STout_valid,
                                   bus_nl.STout_data, bus_nl.STout_channel, 12'h100 + 12'(i), exp_ch); end
            n_checks++; if (in_packet_nl !== 1'b0) begin n_fail++; $display("FAIL nl_in_packet_%0d: got %b want 0", i, in_packet_nl); end
        end
        bus_nl.STin_valid   = 1'b0;
        bus_nl.prefix_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.STout_ready = 1'b0;
        drive(1'b1, 12'h0C1, 5'h09, 1'b1, 1'b0, 1'b1, 2'b10);
        step();
        drive(1'b1, 12'h0C2, 5'h09, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        n_checks++; if (in_packet !== 1'b1 || bus.STin_ready !== 1'b0) begin
            n_fail++; $display("FAIL rm_pre: got inpkt %b inready %b want 1 0", in_packet, bus.STin_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.STout_valid !== 1'b0 || in_packet !== 1'b0 || bus.STout_data !== 12'h000) begin
            n_fail++; $display("FAIL rm_async: got v%b inpkt %b d%h want v0 inpkt 0 d000", bus.STout_valid, in_packet, bus.STout_data); end
        step();
        reset = 1'b0;
        bus.STout_ready = 1'b1;
        drive(1'b1, 12'h0D1, 5'h05, 1'b1, 1'b1, 1'b0, 2'b01);
        #1;
        n_checks++; if (bus.STin_ready !== 1'b0) begin n_fail++; $display("FAIL rm_need_prefix: got %b want 0", bus.STin_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL rm_discarded: got %b want 0", bus.STout_valid); end
        bus.prefix_valid = 1'b1;
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_channel !== 7'h25 || bus.STout_data !== 12'h0D1) begin
            n_fail++; $display("FAIL rm_after: got v%b d%h c%h want v1 d0d1 c25", bus.STout_valid, bus.STout_data, bus.STout_channel); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
    endtask

    task automatic test_back_to_back();
        bus.STout_ready = 1'b1;
        drive(1'b1, 12'h0E1, 5'h01, 1'b1, 1'b1, 1'b1, 2'b10);
        #1;
        n_checks++; if (bus.prefix_ready !== 1'b1) begin n_fail++; $display("FAIL bb_pready0: got %b want 1", bus.prefix_ready); end
        step();
        n_checks++; if (bus.STout_channel !== 7'h41 || in_packet !== 1'b0) begin
            n_fail++; $display("FAIL bb_out0: got c%h inpkt %b want c41 inpkt 0", bus.STout_channel, in_packet); end
        drive(1'b1, 12'h0E2, 5'h02, 1'b1, 1'b1, 1'b1, 2'b11);
        #1;
        n_checks++; if (bus.prefix_ready !== 1'b1) begin n_fail++; $display("FAIL bb_pready1: got %b want 1", bus.prefix_ready); end
        step();
        n_checks++; if (bus.STout_valid !== 1'b1 || bus.STout_channel !== 7'h62 || bus.STout_data !== 12'h0E2 || in_packet !== 1'b0) begin
            n_fail++; $display("FAIL bb_out1: got v%b d%h c%h inpkt %b want v1 d0e2 c62 inpkt 0", bus.STout_valid,
                               bus.STout_data, bus.STout_channel, in_packet); end
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        n_checks++; if (bus.STout_valid !== 1'b0) begin n_fail++; $display("FAIL bb_drain: got %b want 0", bus.STout_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 12'h0, 5'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        bus.STout_ready           = 1'b1;
        bus_nl.STin_valid         = 1'b0;
        bus_nl.STin_data          = '0;
        bus_nl.STin_channel       = '0;
        bus_nl.STin_startofpacket = 1'b0;
        bus_nl.STin_endofpacket   = 1'b0;
        bus_nl.prefix_valid       = 1'b0;
        bus_nl.prefix_data        = '0;
        bus_nl.STout_ready        = 1'b1;
        step();
        test_reset();
        test_packet_lock();
        test_prefix_wait();
        test_stall();
        test_no_lock();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/st_channel_prefix_pipe.md
ST_CHANNEL_PREFIX_PIPE -- requirements
Module: st_channel_prefix_pipe

Interface
REQ-001 Parameter DATA_W, default 12, data beat width in bits.
REQ-002 Parameter CHAN_W, default 5, incoming channel width.
REQ-003 Parameter PREFIX_W, default 2, prefix width; output channel width is PREFIX_W+CHAN_W.
REQ-004 Parameter PACKET_LOCK, default 1; 1 = one prefix per packet, 0 = one prefix per beat.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 prefix_valid  in  1 / prefix_ready  out  1 / prefix_data  in  PREFIX_W  prefix stream, readyLatency 0.
REQ-009 STin_valid  in  1 / STin_ready  out  1 / STin_data  in  DATA_W / STin_channel  in  CHAN_W / STin_startofpacket, STin_endofpacket  in  1 each  Avalon-ST sink, readyLatency 0.
REQ-010 STout_ready  in  1 / STout_valid  out  1 / STout_data  out  DATA_W / STout_channel  out  PREFIX_W+CHAN_W / STout_startofpacket, STout_endofpacket  out  1 each  Avalon-ST source, readyLatency 0.
REQ-011 in_packet  out  1  high while in state IN_PKT.

Function
REQ-012 The block SHALL contain a 2-entry skid buffer (main output register + one skid register); all ST outputs SHALL be driven directly from flops.
REQ-013 need_prefix SHALL be 1 in state IDLE or when PACKET_LOCK=0, else 0.
REQ-014 space SHALL be 1 when the skid register is empty; STin_ready = space & (!need_prefix | prefix_valid); prefix_ready = space & need_prefix & STin_valid.
REQ-015 A beat is accepted when STin_valid & STin_ready; a prefix is consumed exactly when prefix_valid & prefix_ready; the two SHALL coincide whenever need_prefix=1.
REQ-016 Accepted beat SHALL emerge with STout_channel = {prefix, STin_channel}; data, SOP, EOP unchanged; prefix = prefix_data if consumed this beat, else latched prefix.
REQ-017 Latency: beat accepted in cycle N with output stage empty or draining SHALL appear on STout in cycle N+1; throughput one beat/cycle with STout_ready held high.
REQ-018 When STout_valid & !STout_ready and a beat is accepted, it SHALL go to the skid register; space drops next cycle; skid empties into main register on the next STout_ready cycle, order preserved.
REQ-019 State machine (PACKET_LOCK=1): IDLE --accepted beat with !EOP--> IN_PKT (latch prefix_data); IDLE --accepted beat with EOP--> IDLE; IN_PKT --accepted beat with EOP--> IDLE; otherwise hold.
REQ-020 In IDLE any accepted beat SHALL be treated as packet start regardless of STin_startofpacket; SOP received in IN_PKT SHALL NOT re-consume a prefix and SHALL pass through unchanged.
REQ-021 With PACKET_LOCK=0 the state SHALL stay IDLE and in_packet SHALL stay 0.
REQ-022 prefix_valid without STin_valid (or vice versa, when need_prefix=1) SHALL consume nothing.
REQ-023 STout_valid SHALL never deassert without handshake; output payload SHALL stay stable while STout_valid & !STout_ready.

Reset
REQ-024 Reset asserted SHALL immediately clear: STout_valid=0, skid empty, state IDLE, in_packet=0, latched prefix=0, STout_data/channel/SOP/EOP=0.
REQ-025 Reset mid-packet SHALL discard buffered beats; first beat after release SHALL require a new prefix.
REQ-026 STin_ready and prefix_ready SHALL be 0 while reset is high.

Verification
REQ-027 PACKET_LOCK=1, prefix 2'b10, 3-beat packet ch 5'h03, STout_ready=1 -> prefix consumed once on beat 0; STout_channel=7'h43 on all three beats, one cycle after each input; in_packet 1 after beat 0, 0 after beat 2.
REQ-028 PACKET_LOCK=1, prefix_valid=0, STin_valid=1 in IDLE -> STin_ready=0, no output; raise prefix_valid=1 with 2'b01 -> beat accepted same cycle, output channel {2'b01,ch}.
REQ-029 STout_ready=0 for 3 cycles during stream of data 12'h001,002,003 -> two beats buffered, STin_ready=0 after second; release -> outputs 001,002,003 in order, no loss or duplication, payload stable while stalled.
REQ-030 PACKET_LOCK=0, prefixes 0,1,2,3 on 4 beats of one packet -> each beat carries its own prefix; four prefixes consumed; in_packet stays 0.
REQ-031 Reset asserted in IN_PKT with skid full -> same-cycle STout_valid=0, in_packet=0; after release, first beat stalls until prefix_valid=1.
REQ-032 Single-beat packet (SOP=EOP=1) followed back-to-back by another -> each consumes one prefix; state remains IDLE.
